// File: rtl/float_acc_seq.sv
// Sequential accumulator for an 8-bit mini-float ([7:5] exponent, [4:0] mantissa), one operand per handshake.
// Optional FLOAT_ACC_BARREL_EN replaces the serial ALIGN shifter with a one-step barrel shift in CMP.
module float_acc_seq #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       b_q, b_d;
  logic [2:0]       big_exp_q, big_exp_d;
  logic [4:0]       big_man_q, big_man_d;
  logic [4:0]       sm_man_q, sm_man_d;
  logic [2:0]       dist_q, dist_d;
  logic             last_pend_q, last_pend_d;
  logic             empty_q, empty_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [7:0]       big_c, small_c;
  logic [2:0]       dist_c;
  logic [5:0]       sum_c;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    b_d         = b_q;
    big_exp_d   = big_exp_q;
    big_man_d   = big_man_q;
    sm_man_d    = sm_man_q;
    dist_d      = dist_q;
    last_pend_d = last_pend_q;
    empty_d     = empty_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;
    big_c       = acc_q;
    small_c     = b_q;
    dist_c      = 3'd0;
    sum_c       = 6'd0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (empty_q) begin
            acc_d   = in_data;
            empty_d = 1'b0;
            cnt_d   = CNT_W'(1);
            state_d = in_last ? DONE : IDLE;
          end else begin
            b_d         = in_data;
            last_pend_d = in_last;
            if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
            state_d     = CMP;
          end
        end
      end
      CMP: begin
        // Ties go to the accumulator so a saturated 8'hFF always stays the big operand.
        if (acc_q[7:5] < b_q[7:5]) begin
          big_c   = b_q;
          small_c = acc_q;
        end
        dist_c    = big_c[7:5] - small_c[7:5];
        big_exp_d = big_c[7:5];
        big_man_d = big_c[4:0];
`ifdef FLOAT_ACC_BARREL_EN
        sm_man_d  = small_c[4:0] >> dist_c;
        dist_d    = 3'd0;
        state_d   = ADD;
`else
        sm_man_d  = small_c[4:0];
        dist_d    = dist_c;
        state_d   = (dist_c != 3'd0) ? ALIGN : ADD;
`endif
      end
      ALIGN: begin
        sm_man_d = sm_man_q >> 1;
        dist_d   = dist_q - 3'd1;
        if (dist_q == 3'd1) state_d = ADD;
      end
      ADD: begin
        sum_c = {1'b0, big_man_q} + {1'b0, sm_man_q};
        if (!sum_c[5]) begin
          acc_d = {big_exp_q, sum_c[4:0]};
        end else if (big_exp_q == 3'b111) begin
          acc_d = 8'hFF;
          sat_d = 1'b1;
        end else begin
          acc_d = {big_exp_q + 3'd1, sum_c[5:1]};
        end
        state_d = last_pend_q ? DONE : IDLE;
      end
      DONE: begin
        if (out_ready) begin
          empty_d = 1'b1;
          sat_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 8'h00;
      b_q         <= 8'h00;
      big_exp_q   <= 3'd0;
      big_man_q   <= 5'd0;
      sm_man_q    <= 5'd0;
      dist_q      <= 3'd0;
      last_pend_q <= 1'b0;
      empty_q     <= 1'b1;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      big_exp_q   <= big_exp_d;
      big_man_q   <= big_man_d;
      sm_man_q    <= sm_man_d;
      dist_q      <= dist_d;
      last_pend_q <= last_pend_d;
      empty_q     <= empty_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = acc_q;
  assign out_sat   = sat_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_float_acc_seq.sv
// Randomized and directed checks of float_acc_seq against an arithmetic reference model.
module tb_float_acc_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_sat, busy;
  logic [7:0] out_data;
  logic [3:0] out_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] ops[$];

  always #5 clk = ~clk;

  float_acc_seq #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_count(out_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference add: align the smaller-exponent mantissa with plain integer division, add, renormalise.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    int be, bm, se, sm, s;
    logic [7:0] r;
    if (int'(a[7:5]) >= int'(b[7:5])) begin
      be = int'(a[7:5]); bm = int'(a[4:0]); se = int'(b[7:5]); sm = int'(b[4:0]);
    end else begin
      be = int'(b[7:5]); bm = int'(b[4:0]); se = int'(a[7:5]); sm = int'(a[4:0]);
    end
    s = bm + sm / (2 ** (be - se));
    if (s < 32) begin
      r = {3'(be), 5'(s)};
      return {1'b0, r};
    end
    if (be == 7) return 9'h1FF;
    r = {3'(be + 1), 5'(s / 2)};
    return {1'b0, r};
  endfunction

  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = (int'(a[7:5]) >= int'(b[7:5])) ? int'(a[7:5]) - int'(b[7:5]) : int'(b[7:5]) - int'(a[7:5]);
`ifdef FLOAT_ACC_BARREL_EN
    d = 0;
`endif
    return 2 + d;
  endfunction

  task automatic run_sum(input string tag, input bit do_hs);
    logic [7:0] acc;
    logic [8:0] r;
    logic       sat;
    int         k, lat;
    acc = 8'h00;
    sat = 1'b0;
    foreach (ops[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = ops[i];
      in_last  = (i == ops.size() - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i == 0) begin
        acc = ops[0];
        lat = 0;
      end else begin
        r   = ref_add(acc, ops[i]);
        lat = ref_lat(acc, ops[i]);
        acc = r[7:0];
        sat = sat | r[8];
      end
      k = 0;
      while (!(in_ready || out_valid) && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      chk({tag, ".lat"}, k, lat);
    end
    chk({tag, ".vld"}, out_valid, 1);
    chk({tag, ".data"}, out_data, acc);
    chk({tag, ".sat"}, out_sat, sat);
    chk({tag, ".cnt"}, out_count, (ops.size() > 15) ? 15 : ops.size());
    if (do_hs) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".hs_rdy"}, in_ready, 1);
    end
  endtask

  initial begin
    logic [7:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst.vld", out_valid, 0);
    chk("rst.rdy", in_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.data", out_data, 8'h00);
    chk("rst.cnt", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    ops = '{8'h45};               run_sum("single", 1);
    ops = '{8'h22, 8'h41};        run_sum("align", 1);
    ops = '{8'h3F, 8'h21};        run_sum("carry", 1);
    ops = '{8'hFF, 8'hE1, 8'h05}; run_sum("satur", 1);

    // Result held under backpressure while a new operand is offered.
    ops = '{8'h12, 8'h34}; run_sum("hold", 0);
    held = out_data;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold.data", out_data, held);
      chk("hold.rdy", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold.rel_rdy", in_ready, 1);
    chk("hold.rel_cnt", out_count, 0);
    chk("hold.rel_vld", out_valid, 0);

    // Reset during ALIGN abandons the sum.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h20; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hE0; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    chk("mid.busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid.vld", out_valid, 0);
    chk("mid.rdy", in_ready, 1);
    chk("mid.busy0", busy, 0);
    chk("mid.data", out_data, 8'h00);
    chk("mid.cnt", out_count, 0);
    chk("mid.sat", out_sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ops = '{8'h11}; run_sum("post_rst", 1);

    // Counter saturation.
    ops = {};
    for (int i = 0; i < 17; i++) ops.push_back(8'h01);
    run_sum("cntsat", 1);

    for (int t = 0; t < 25; t++) begin
      int len;
      len = $urandom_range(1, 5);
      ops = {};
      for (int i = 0; i < len; i++) ops.push_back(8'($urandom_range(0, 255)));
      run_sum("rnd", 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/float_acc_seq.md
FLOAT_ACC_SEQ -- requirements
Module: float_acc_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the operand counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand offered.
REQ-005 SHALL have port in_ready  output  1  operand accepted when in_valid&&in_ready at a clock edge.
REQ-006 SHALL have port in_data  input  8  operand: [7:5] unsigned exponent, [4:0] unsigned mantissa.
REQ-007 SHALL have port in_last  input  1  marks the final operand of a sum; sampled with in_data.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  result consumed when out_valid&&out_ready at a clock edge.
REQ-010 SHALL have port out_data  output  8  accumulated sum, same format as in_data.
REQ-011 SHALL have port out_sat  output  1  sticky: the sum saturated to 8'hFF.
REQ-012 SHALL have port out_count  output  CNT_W  operands accepted in this sum; saturates at 2^CNT_W-1.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CMP, ALIGN, ADD, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 In IDLE, first operand of a sum (empty flag set): acc <= in_data; empty flag cleared; out_count <= 1; next state DONE if in_last, else IDLE.
REQ-016 In IDLE, any later operand: latch it as B, set last_pend <= in_last, increment out_count, go to CMP.
REQ-017 CMP (1 cycle): big = acc when acc[7:5] >= B[7:5], otherwise B; small = the other operand; dist = big exp - small exp (3 bits); go to ALIGN if dist != 0, else ADD.
REQ-018 ALIGN: shift the small mantissa right by 1 bit per cycle, discarding LSBs, and decrement dist; go to ADD in the cycle dist reaches 0 (dist cycles total).
REQ-019 ADD (1 cycle): s[5:0] = big mant + aligned small mant.
- No carry: acc <= {big exp, s[4:0]}.
- Carry with big exp == 3'b111: acc <= 8'hFF and out_sat <= 1.
- Carry otherwise: acc <= {big exp+1, s[5:1]}.
REQ-020 After ADD: go to DONE if last_pend, else IDLE.
REQ-021 Per-operand latency (accept edge to return to IDLE/DONE) SHALL be 2+dist cycles; the first operand takes 1 cycle.
REQ-022 DONE: out_data = acc, held stable until handshake; on out_ready: go to IDLE, set empty flag, clear out_sat and out_count.
REQ-023 in_valid outside IDLE SHALL be ignored, with no state change.
REQ-024 A saturated acc (8'hFF) SHALL remain 8'hFF for any further operand.
REQ-025 out_data SHALL equal acc in all states; out_count SHALL hold at 2^CNT_W-1 once reached.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, acc 0, out_data 0, out_valid 0, out_sat 0, out_count 0, busy 0, in_ready 1, empty flag set, dist 0, last_pend 0.
REQ-027 Reset in any state, including mid-ALIGN, SHALL abandon the sum with no partial result emitted.

Configuration
REQ-028 With macro FLOAT_ACC_BARREL_EN defined: CMP shifts the small mantissa right by dist in one step and goes directly to ADD; ALIGN is never entered; per-operand latency is a fixed 2 cycles.
REQ-029 Without FLOAT_ACC_BARREL_EN: serial ALIGN per REQ-018; results SHALL be bit-identical in both builds.

Verification
REQ-030 Accept 8'h45 with in_last=1 -> next cycle out_valid=1, out_data=8'h45, out_count=1, out_sat=0.
REQ-031 8'h22 then 8'h41 (last) -> big=8'h41, dist=1, 1 ALIGN cycle, out_data=8'h42, out_valid 3 cycles after 2nd accept (2 with FLOAT_ACC_BARREL_EN).
REQ-032 8'h3F then 8'h21 (last) -> carry, out_data=8'h50, out_sat=0.
REQ-033 8'hFF then 8'hE1 then 8'h05 (last) -> out_data=8'hFF, out_sat=1, out_count=3.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> out_data stable, in_ready=0, nothing accepted; out_ready=1 -> IDLE, out_count=0.
REQ-035 8'h20 then 8'hE0: assert rst_n=0 during ALIGN -> all outputs at reset values at once; after release, 8'h11 (last) -> out_data=8'h11.
